bit_serial_sum_engine: RTL and testbench

BIT_SERIAL_SUM_ENGINE -- requirements
Module: bit_serial_sum_engine

---
 rtl/bit_serial_sum_engine_pkg.sv | 20 ++
 rtl/lane_popcount.sv | 20 ++
 rtl/bit_serial_sum_engine.sv | 123 ++++++++++++
 tb/tb_bit_serial_sum_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_sum_engine_pkg.sv
// Shared types for the bit-serial sum engine: FSM state encoding and a
// constant-foldable ceil(log2) helper used for result/popcount widths.
package bit_serial_sum_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (value > (1 << i)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_popcount.sv
// Combinational population count over the M lane bits of one slice.
module lane_popcount
  import bit_serial_sum_engine_pkg::*;
#(
  parameter int M = 32
) (
  input  logic [M-1:0]              bits_i,
  output logic [clog2(M+1)-1:0]     count_o
);

  localparam int CW = clog2(M + 1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < M; i++) begin
      count_o = count_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/bit_serial_sum_engine.sv
// Sums M operands that arrive one bit-slice per beat (LSB first).
// Define BIT_SERIAL_SUM_SIGNED_EN to add signed_mode (two's-complement operands).
module bit_serial_sum_engine
  import bit_serial_sum_engine_pkg::*;
#(
  parameter  int M  = 32,
  parameter  int N  = 32,
  localparam int RW = N + clog2(M + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [M-1:0]  lane_en,
`ifdef BIT_SERIAL_SUM_SIGNED_EN
  input  logic          signed_mode,
`endif
  input  logic          slice_valid,
  input  logic [M-1:0]  slice_data,
  output logic          slice_ready,
  output logic          busy,
  output logic [RW-1:0] result,
  output logic          result_valid,
  input  logic          result_ready,
  output state_t        state_dbg,
  output logic [RW-1:0] acc_dbg
);

  localparam int CW = clog2(M + 1);
  localparam int IW = clog2(N);

  // Handshakes: a slice transfers on a rising edge where slice_valid && slice_ready;
  // a result transfers where result_valid && result_ready. Neither side may
  // retract valid before its transfer, and ready never depends on valid.

  state_t          state_q, state_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [M-1:0]    mask_q, mask_d;
  logic [CW-1:0]   pop_count;
  logic [RW-1:0]   term;
  logic            slice_accept;
  logic            start_accept;
  logic            last_slice;
`ifdef BIT_SERIAL_SUM_SIGNED_EN
  logic            signed_q, signed_d;
`endif

  lane_popcount #(.M(M)) u_popcount (
    .bits_i  (slice_data & mask_q),
    .count_o (pop_count)
  );

  assign start_accept = (state_q == ST_IDLE) && start;
  assign slice_accept = (state_q == ST_ACCUM) && slice_valid;
  assign last_slice   = (idx_q == IW'(N - 1));
  assign term         = RW'(pop_count) << idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      mask_q   <= '0;
`ifdef BIT_SERIAL_SUM_SIGNED_EN
      signed_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
`ifdef BIT_SERIAL_SUM_SIGNED_EN
      signed_q <= signed_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ACCUM;
      ST_ACCUM: if (slice_valid && last_slice) state_d = ST_DONE;
      ST_DONE:  if (result_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
`ifdef BIT_SERIAL_SUM_SIGNED_EN
    signed_d = signed_q;
`endif
    if (start_accept) begin
      acc_d    = '0;
      idx_d    = '0;
      mask_d   = lane_en;
`ifdef BIT_SERIAL_SUM_SIGNED_EN
      signed_d = signed_mode;
`endif
    end else if (slice_accept) begin
      idx_d = idx_q + 1'b1;
`ifdef BIT_SERIAL_SUM_SIGNED_EN
      // The top slice carries the sign weight -2^(N-1) for two's-complement lanes.
      if (signed_q && last_slice) acc_d = acc_q - term;
      else                        acc_d = acc_q + term;
`else
      acc_d = acc_q + term;
`endif
    end
  end

  always_comb begin
    slice_ready  = (state_q == ST_ACCUM);
    busy         = (state_q == ST_ACCUM) || (state_q == ST_DONE);
    result_valid = (state_q == ST_DONE);
    result       = acc_q;
    state_dbg    = state_q;
    acc_dbg      = acc_q;
  end

endmodule

// File: tb/tb_bit_serial_sum_engine.sv
// Self-checking bench for bit_serial_sum_engine at M=4, N=4: directed table,
// multi-cycle corner sequences and randomized runs against an arithmetic model.
module tb_bit_serial_sum_engine;
  import bit_serial_sum_engine_pkg::*;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int RW = N + clog2(M + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [M-1:0]  lane_en;
  logic          slice_valid;
  logic [M-1:0]  slice_data;
  logic          slice_ready;
  logic          busy;
  logic [RW-1:0] result;
  logic          result_valid;
  logic          result_ready;
  state_t        state_dbg;
  logic [RW-1:0] acc_dbg;
`ifdef BIT_SERIAL_SUM_SIGNED_EN
  logic          sgn_drv;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  bit_serial_sum_engine #(.M(M), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .lane_en      (lane_en),
`ifdef BIT_SERIAL_SUM_SIGNED_EN
    .signed_mode  (sgn_drv),
`endif
    .slice_valid  (slice_valid),
    .slice_data   (slice_data),
    .slice_ready  (slice_ready),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .state_dbg    (state_dbg),
    .acc_dbg      (acc_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*M-1:0] ops;
    logic [M-1:0]   mask;
    logic           sgn;
    int             stall_at;
    int             stall_n;
    logic [RW-1:0]  exp;
    string          name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [M-1:0] get_slice(input logic [4*M-1:0] ops, input int k);
    logic [M-1:0] s;
    for (int i = 0; i < M; i++) s[i] = ops[i*N + k];
    return s;
  endfunction

  // Plain arithmetic reference: add the enabled operands as integers.
  function automatic logic [RW-1:0] model_sum(input logic [4*M-1:0] ops,
                                               input logic [M-1:0] mask, input logic sgn);
    int sum;
    int v;
    sum = 0;
    for (int i = 0; i < M; i++) begin
      if (mask[i]) begin
        v = int'(ops[i*N +: N]);
        if (sgn && v >= (1 << (N - 1))) v = v - (1 << N);
        sum += v;
      end
    end
    return RW'(sum);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sum(input logic [4*M-1:0] ops, input logic [M-1:0] mask, input logic sgn,
                         input int stall_at, input int stall_n, input logic [RW-1:0] exp,
                         input string name);
    logic [RW-1:0] held;
    start = 1'b1;
    lane_en = mask;
`ifdef BIT_SERIAL_SUM_SIGNED_EN
    sgn_drv = sgn;
`endif
    tick();
    start = 1'b0;
    lane_en = '0;
    check({name, ":ready_in_accum"}, 32'(slice_ready), 32'd1);
    for (int k = 0; k < N; k++) begin
      if (k == stall_at) begin
        held = acc_dbg;
        slice_valid = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          slice_data = 4'($urandom_range(0, 15));
          tick();
          check({name, ":stall_acc"}, 32'(acc_dbg), 32'(held));
        end
      end
      slice_valid = 1'b1;
      slice_data = get_slice(ops, k);
      tick();
      slice_valid = 1'b0;
      slice_data = '0;
      if (k == N - 2) check({name, ":no_early_valid"}, 32'(result_valid), 32'd0);
    end
    check({name, ":valid_latency"}, 32'(result_valid), 32'd1);
    check({name, ":result"}, 32'(result), 32'(exp));
  endtask

  task automatic collect(input string name, input int delay, input logic [RW-1:0] exp);
    for (int d = 0; d < delay; d++) begin
      tick();
      check({name, ":held_result"}, 32'(result), 32'(exp));
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({name, ":valid_drop"}, 32'(result_valid), 32'd0);
    check({name, ":back_idle"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    logic [4*M-1:0] r_ops;
    logic [M-1:0]   r_mask;
    logic           r_sgn;
    logic [RW-1:0]  r_exp;

    tbl.push_back('{16'hF753, 4'hF, 1'b0, -1, 0, 7'd30, "req032"});
    tbl.push_back('{16'hF753, 4'h7, 1'b0, -1, 0, 7'd15, "req034"});
    tbl.push_back('{16'h7753, 4'h7, 1'b0, -1, 0, 7'd15, "req034_lane3"});
    tbl.push_back('{16'hF753, 4'hF, 1'b0,  2, 3, 7'd30, "req035_stall"});
    tbl.push_back('{16'hFFFF, 4'hF, 1'b0, -1, 0, 7'd60, "all15"});
    tbl.push_back('{16'hFFFF, 4'h0, 1'b0, -1, 0, 7'd0,  "mask0"});
    tbl.push_back('{16'h0000, 4'hF, 1'b0,  1, 2, 7'd0,  "ops0"});
    tbl.push_back('{16'h8421, 4'hA, 1'b0, -1, 0, 7'd10, "sparse"});
`ifdef BIT_SERIAL_SUM_SIGNED_EN
    tbl.push_back('{16'hF753, 4'hF, 1'b1, -1, 0, 7'd14, "req033_signed"});
    tbl.push_back('{16'hFFFF, 4'hF, 1'b1, -1, 0, 7'h7C, "signed_neg4"});
    tbl.push_back('{16'h8888, 4'hF, 1'b1, -1, 0, 7'h60, "signed_min"});
`endif

    rst = 1'b1;
    start = 1'b0;
    lane_en = '0;
    slice_valid = 1'b0;
    slice_data = '0;
    result_ready = 1'b0;
`ifdef BIT_SERIAL_SUM_SIGNED_EN
    sgn_drv = 1'b0;
`endif
    tick();
    tick();
    check("reset:state", 32'(state_dbg), 32'(ST_IDLE));
    check("reset:result", 32'(result), 32'd0);
    check("reset:valid", 32'(result_valid), 32'd0);
    check("reset:ready", 32'(slice_ready), 32'd0);
    check("reset:busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      run_sum(tbl[i].ops, tbl[i].mask, tbl[i].sgn, tbl[i].stall_at, tbl[i].stall_n,
              tbl[i].exp, tbl[i].name);
      collect(tbl[i].name, 0, tbl[i].exp);
    end

    // Consumer holds off for 5 cycles while start is pulsed: nothing may move.
    run_sum(16'hF753, 4'hF, 1'b0, -1, 0, 7'd30, "req036");
    for (int c = 0; c < 5; c++) begin
      start = 1'b1;
      lane_en = '0;
      tick();
      check("req036:hold_result", 32'(result), 32'd30);
      check("req036:hold_valid", 32'(result_valid), 32'd1);
      check("req036:hold_state", 32'(state_dbg), 32'(ST_DONE));
    end
    start = 1'b0;
    collect("req036", 0, 7'd30);

    // Reset mid-run, asserted alongside start and both handshakes.
    start = 1'b1;
    lane_en = 4'hF;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      slice_valid = 1'b1;
      slice_data = get_slice(16'hF753, k);
      tick();
    end
    rst = 1'b1;
    start = 1'b1;
    result_ready = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    slice_valid = 1'b0;
    result_ready = 1'b0;
    check("req037:state", 32'(state_dbg), 32'(ST_IDLE));
    check("req037:result", 32'(result), 32'd0);
    check("req037:valid", 32'(result_valid), 32'd0);
    check("req037:ready", 32'(slice_ready), 32'd0);
    check("req037:busy", 32'(busy), 32'd0);
    tick();
    check("req037:still_idle", 32'(state_dbg), 32'(ST_IDLE));
    run_sum(16'hFFFF, 4'hF, 1'b0, -1, 0, 7'd60, "req037_rerun");
    collect("req037_rerun", 0, 7'd60);

    for (int t = 0; t < 40; t++) begin
      r_ops = 16'($urandom);
      r_mask = 4'($urandom_range(0, 15));
`ifdef BIT_SERIAL_SUM_SIGNED_EN
      r_sgn = 1'($urandom_range(0, 1));
`else
      r_sgn = 1'b0;
`endif
      r_exp = model_sum(r_ops, r_mask, r_sgn);
      run_sum(r_ops, r_mask, r_sgn, $urandom_range(0, N), $urandom_range(0, 3), r_exp, "rand");
      collect("rand", $urandom_range(0, 3), r_exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
